rom_loader: RTL and testbench

- Boot-time writer for the instruction memory's write port (we/addr/data).
- Receives a framed byte stream from a byte source (UART RX or debug bridge) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Holds the CPU core in reset until a complete frame with a valid checksum has been written.

---
 rtl/loader_pkg.sv | 16 +
 rtl/rom_loader.sv | 172 +++++++++++++++++
 tb/tb_rom_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/rom_loader.sv
// Receives a framed byte stream, assembles little-endian words and writes them
// to instruction memory; releases the CPU hold only after a good checksum.
module rom_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [16:0] MAX_WORDS_17 = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        is_sync;
  logic [15:0] len_full;
  logic [31:0] word_next;

  // No byte can be taken while the write strobe is out, nor while in reset.
  assign rx_ready_o = rst & ~we_q;
  assign accept     = rx_valid_i & rx_ready_o;
  assign is_sync    = (rx_data_i == SYNC_BYTE);
  assign len_full   = {rx_data_i, len_q[7:0]};
  assign word_next  = {rx_data_i, asm_q[31:8]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (is_sync) begin
            state_d = LEN0;
            len_d   = '0;
            csum_d  = '0;
          end
        end
        LEN0: begin
          len_d   = {8'h00, rx_data_i};
          state_d = LEN1;
        end
        LEN1: begin
          len_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS_17) begin
            state_d = ERR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          asm_d  = word_next;
          csum_d = csum_q ^ rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = word_next;
            addr_d = ADDR_BASE + {14'd0, idx_q, 2'b00};
            idx_d  = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
              state_d = CSUM;
            end
          end
        end
        CSUM: begin
          if (rx_data_i == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
            hold_d  = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
          end
        end
        DONE, ERR: begin
          // Resynchronisation is only possible once a frame has finished.
          if (is_sync) begin
            state_d = LEN0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            hold_d  = 1'b1;
            len_d   = '0;
            csum_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_BASE;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign hold_o = hold_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: frames are streamed with valid held high and
// every memory write is captured and compared against hand-computed words.
module tb_rom_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic        hold_o;
  logic        done_o;
  logic        err_o;

  int checks;
  int errors;
  int ready_viol;

  logic [63:0] obs_q[$];
  logic [7:0]  fr_q[$];

  rom_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .hold_o     (hold_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (we_o) obs_q.push_back({addr_o, data_o});
    if (rst && (rx_ready_o !== ~we_o)) ready_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Entered and left on a falling edge; valid stays high afterwards.
  task automatic put_byte(input logic [7:0] b);
    int n;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    n = 0;
    while (!rx_ready_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8) chk("ready_timeout", 32'(rx_ready_o), 32'd1);
    @(negedge clk);
  endtask

  // Sends fr_q; data bytes start at index d0. After each 4th data byte the
  // write strobe must be out on the very next cycle with ready low.
  task automatic send_frame(input int nwords, input int d0);
    for (int i = 0; i < fr_q.size(); i++) begin
      put_byte(fr_q[i]);
      if (i >= d0 && i < d0 + 4 * nwords && ((i - d0) % 4) == 3) begin
        chk("we_latency", 32'(we_o), 32'd1);
        chk("ready_in_we", 32'(rx_ready_o), 32'd0);
      end
    end
    rx_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_writes(input int n, input logic [63:0] e0, input logic [63:0] e1);
    logic [63:0] exp_w;
    chk("write_count", 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      exp_w = (i == 0) ? e0 : e1;
      if (i < obs_q.size()) begin
        chk("write_addr", obs_q[i][63:32], exp_w[63:32]);
        chk("write_data", obs_q[i][31:0], exp_w[31:0]);
      end
    end
    obs_q.delete();
  endtask

  task automatic expect_flags(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 32'(done_o), 32'(d));
    chk({tag, "_err"},  32'(err_o),  32'(e));
    chk({tag, "_hold"}, 32'(hold_o), 32'(h));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(rx_ready_o), 32'd0);
    chk("rst_we",    32'(we_o),       32'd0);
    chk("rst_addr",  addr_o,          32'h0);
    chk("rst_data",  data_o,          32'h0);
    expect_flags("rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs_q.delete();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ready_viol = 0;
    rst        = 1'b1;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    #2;
    do_reset();

    // Good two-word frame; checksum 13^93^10 = 90.
    fr_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(2, 3);
    expect_writes(2, {32'h0, 32'h0000_0013}, {32'h4, 32'h0010_0093});
    expect_flags("good", 1'b1, 1'b0, 1'b0);

    // From DONE a sync restarts the frame, then the checksum is wrong.
    put_byte(8'hA5);
    expect_flags("restart", 1'b0, 1'b0, 1'b1);
    fr_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame(2, 2);
    expect_writes(2, {32'h0, 32'h0000_0013}, {32'h4, 32'h0010_0093});
    expect_flags("badsum", 1'b0, 1'b1, 1'b1);

    // Length 4097 is one above the limit: error without any write.
    fr_q = '{8'hA5, 8'h01, 8'h10};
    send_frame(0, 3);
    expect_writes(0, 64'h0, 64'h0);
    expect_flags("toolong", 1'b0, 1'b1, 1'b1);

    // Empty frame with zero checksum recovers from ERR.
    fr_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0, 3);
    expect_writes(0, 64'h0, 64'h0);
    expect_flags("empty", 1'b1, 1'b0, 1'b0);

    // Sync bytes inside the payload are plain data.
    fr_q = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    send_frame(1, 3);
    expect_writes(1, {32'h0, 32'hA5A5_A5A5}, 64'h0);
    expect_flags("syncdata", 1'b1, 1'b0, 1'b0);

    // Noise ahead of the sync byte is dropped while idle.
    do_reset();
    fr_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(2, 5);
    expect_writes(2, {32'h0, 32'h0000_0013}, {32'h4, 32'h0010_0093});
    expect_flags("noise", 1'b1, 1'b0, 1'b0);

    // Reset after two data bytes: nothing written, then a clean reload.
    fr_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_frame(0, 3);
    do_reset();
    chk("midrst_writes", 32'(obs_q.size()), 32'd0);
    fr_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(2, 3);
    expect_writes(2, {32'h0, 32'h0000_0013}, {32'h4, 32'h0010_0093});
    expect_flags("reload", 1'b1, 1'b0, 1'b0);

    chk("ready_vs_we", 32'(ready_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
